// File: rtl/rf_pkg.sv
// Shared defaults and helper functions for the scoreboarded register file.
package rf_pkg;

    localparam int unsigned DefaultXlen  = 32;
    localparam int unsigned DefaultNregs = 32;
    // Widest busy vector popcount() accepts; narrower vectors are zero-extended.
    localparam int unsigned MaxNregs     = 1024;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

    function automatic int unsigned popcount(input logic [MaxNregs-1:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MaxNregs; i++) begin
            if (bits[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits plus a registered count of how many are set.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = DefaultNregs,
    localparam int unsigned AW   = addr_width(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_reg_i,
    input  logic             issue_i,
    input  logic [AW-1:0]    issue_reg_i,
    input  logic             flush_i,
    output logic [NREGS-1:0] busy_o,
    output logic [AW:0]      busy_cnt_o
);

    logic [NREGS-1:0]    busy_q, busy_d;
    logic [AW:0]         cnt_q, cnt_d;
    logic [MaxNregs-1:0] busy_ext;

    // Clear before set so a same-cycle issue beats both flush and writeback.
    always_comb begin
        busy_d = flush_i ? '0 : busy_q;
        if (wr_en_i) busy_d[wr_reg_i] = 1'b0;
        if (issue_i && (issue_reg_i != '0)) busy_d[issue_reg_i] = 1'b1;
        busy_d[0] = 1'b0;
        busy_ext = '0;
        busy_ext[NREGS-1:0] = busy_d;
        cnt_d = (AW+1)'(popcount(busy_ext));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with x0 hardwired to zero, optional write
// forwarding and a load scoreboard tracking pending destinations.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = DefaultXlen,
    parameter int unsigned NREGS  = DefaultNregs,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = addr_width(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NRD-1:0][AW-1:0]    Read_reg,
    output logic [NRD-1:0][XLEN-1:0]  Read_data,
    output logic [NRD-1:0]            Read_busy,
    input  logic                      RegWrite,
    input  logic [AW-1:0]             Write_reg,
    input  logic [XLEN-1:0]           Write_data,
    input  logic                      Issue,
    input  logic [AW-1:0]             Issue_reg,
    input  logic                      Flush,
    output logic [AW:0]               Busy_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_en;

    assign wr_en = RegWrite && (Write_reg != '0);

    // Entry 0 is never written, so it reads as zero without a special case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else if (wr_en) begin
            regs_q[Write_reg] <= Write_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic hit;
        // Forwarding is gated by rst_n so outputs stay zero throughout reset.
        assign hit          = (BYPASS != 0) && rst_n && wr_en && (Write_reg == Read_reg[i]);
        assign Read_data[i] = hit ? Write_data : regs_q[Read_reg[i]];
        assign Read_busy[i] = !hit && busy[Read_reg[i]];
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wr_en_i     (RegWrite),
        .wr_reg_i    (Write_reg),
        .issue_i     (Issue),
        .issue_reg_i (Issue_reg),
        .flush_i     (Flush),
        .busy_o      (busy),
        .busy_cnt_o  (Busy_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Checks a forwarding and a non-forwarding instance against a behavioural model.
module tb_reg_file_sb;

    localparam int unsigned XW = 32;
    localparam int unsigned NR = 32;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NP-1:0][AW-1:0]   rd_reg;
    logic [NP-1:0][XW-1:0]   rd_data_b, rd_data_n;
    logic [NP-1:0]           rd_busy_b, rd_busy_n;
    logic                    we;
    logic [AW-1:0]           wr_reg;
    logic [XW-1:0]           wr_data;
    logic                    iss;
    logic [AW-1:0]           iss_reg;
    logic                    flush;
    logic [AW:0]             cnt_b, cnt_n;

    int errors = 0;
    int checks = 0;

    logic [XW-1:0] m_mem  [NR];
    bit            m_busy [NR];

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(XW), .NREGS(NR), .NRD(NP), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .Read_reg(rd_reg), .Read_data(rd_data_b),
        .Read_busy(rd_busy_b), .RegWrite(we), .Write_reg(wr_reg), .Write_data(wr_data),
        .Issue(iss), .Issue_reg(iss_reg), .Flush(flush), .Busy_cnt(cnt_b)
    );

    reg_file_sb #(.XLEN(XW), .NREGS(NR), .NRD(NP), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .Read_reg(rd_reg), .Read_data(rd_data_n),
        .Read_busy(rd_busy_n), .RegWrite(we), .Write_reg(wr_reg), .Write_data(wr_data),
        .Issue(iss), .Issue_reg(iss_reg), .Flush(flush), .Busy_cnt(cnt_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int r = 0; r < NR; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    // Applies the architectural effect of one rising edge to the model.
    task automatic model_edge();
        if (!rst_n) return;
        if (flush) for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
        if (we && wr_reg != 0) begin
            m_mem[wr_reg]  = wr_data;
            m_busy[wr_reg] = 1'b0;
        end
        if (iss && iss_reg != 0) m_busy[iss_reg] = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        for (int p = 0; p < NP; p++) begin
            int a;
            bit fwd;
            logic [XW-1:0] exp_b, exp_n;
            logic exp_bb, exp_bn;
            a      = int'(rd_reg[p]);
            fwd    = rst_n && we && (int'(wr_reg) == a) && (a != 0);
            exp_n  = rst_n ? m_mem[a] : '0;
            exp_b  = fwd ? wr_data : exp_n;
            exp_bn = rst_n ? m_busy[a] : 1'b0;
            exp_bb = fwd ? 1'b0 : exp_bn;
            check($sformatf("%s.data_byp[%0d]", tag, p), 64'(rd_data_b[p]), 64'(exp_b));
            check($sformatf("%s.data_nob[%0d]", tag, p), 64'(rd_data_n[p]), 64'(exp_n));
            check($sformatf("%s.busy_byp[%0d]", tag, p), 64'(rd_busy_b[p]), 64'(exp_bb));
            check($sformatf("%s.busy_nob[%0d]", tag, p), 64'(rd_busy_n[p]), 64'(exp_bn));
        end
        check({tag, ".cnt_byp"}, 64'(cnt_b), 64'(model_count()));
        check({tag, ".cnt_nob"}, 64'(cnt_n), 64'(model_count()));
    endtask

    task automatic idle();
        we = 1'b0; iss = 1'b0; flush = 1'b0;
        wr_reg = '0; wr_data = '0; iss_reg = '0;
    endtask

    // Inputs are driven just after a falling edge; outputs sampled 1 ns later.
    task automatic eval(input string tag);
        #1;
        check_outputs(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rd_reg = '0;
        model_reset();
        @(negedge clk);

        // Reset: outputs zero even with a forwardable write pending
        rd_reg[0] = 5'd7; rd_reg[1] = 5'd0;
        we = 1'b1; wr_reg = 5'd7; wr_data = 32'h1111_2222;
        eval("reset");
        check("reset.cnt_const", 64'(cnt_b), 64'd0);
        advance();
        // Write in flight at reset must be discarded
        idle();
        rst_n = 1'b1;
        rd_reg[0] = 5'd7; rd_reg[1] = 5'd7;
        eval("post_reset");
        check("post_reset.x7", 64'(rd_data_b[0]), 64'd0);

        // Write x5, read both ports next cycle
        we = 1'b1; wr_reg = 5'd5; wr_data = 32'hDEAD_BEEF;
        rd_reg[0] = 5'd1; rd_reg[1] = 5'd2;
        eval("wr_x5");
        advance();
        idle();
        rd_reg[0] = 5'd5; rd_reg[1] = 5'd5;
        eval("rd_x5");
        check("rd_x5.p0", 64'(rd_data_b[0]), 64'hDEAD_BEEF);
        check("rd_x5.p1", 64'(rd_data_n[1]), 64'hDEAD_BEEF);
        check("rd_x5.busy", 64'(rd_busy_b), 64'd0);

        // x0 ignores writes and issues
        we = 1'b1; wr_reg = 5'd0; wr_data = 32'h1234_5678;
        rd_reg[0] = 5'd0; rd_reg[1] = 5'd0;
        eval("wr_x0");
        check("wr_x0.fwd", 64'(rd_data_b[0]), 64'd0);
        advance();
        idle();
        iss = 1'b1; iss_reg = 5'd0;
        eval("rd_x0");
        check("rd_x0.data", 64'(rd_data_b[1]), 64'd0);
        advance();
        idle();
        eval("iss_x0");
        check("iss_x0.cnt", 64'(cnt_b), 64'd0);

        // Same-cycle forwarding vs none
        we = 1'b1; wr_reg = 5'd7; wr_data = 32'hA5A5_A5A5;
        rd_reg[0] = 5'd7; rd_reg[1] = 5'd7;
        eval("byp_x7");
        check("byp_x7.byp", 64'(rd_data_b[0]), 64'hA5A5_A5A5);
        check("byp_x7.nob", 64'(rd_data_n[0]), 64'd0);
        advance();

        // Scoreboard: issue, issue+write collision, flush
        idle();
        iss = 1'b1; iss_reg = 5'd3;
        eval("iss_x3");
        advance();
        iss_reg = 5'd4;
        eval("iss_x4");
        advance();
        idle();
        rd_reg[0] = 5'd3; rd_reg[1] = 5'd4;
        eval("two_busy");
        check("two_busy.cnt", 64'(cnt_b), 64'd2);
        we = 1'b1; wr_reg = 5'd3; wr_data = 32'h0000_0033;
        iss = 1'b1; iss_reg = 5'd3;
        eval("wr_iss_x3");
        advance();
        idle();
        eval("after_coll");
        check("after_coll.busy_x3", 64'(rd_busy_b[0]), 64'd1);
        check("after_coll.cnt", 64'(cnt_n), 64'd2);
        check("after_coll.data", 64'(rd_data_b[0]), 64'h33);
        flush = 1'b1;
        eval("flush");
        advance();
        idle();
        eval("after_flush");
        check("after_flush.cnt", 64'(cnt_b), 64'd0);

        // Asynchronous reset between edges
        we = 1'b1; wr_reg = 5'd9; wr_data = 32'h55;
        advance();
        idle();
        iss = 1'b1; iss_reg = 5'd9;
        advance();
        idle();
        rd_reg[0] = 5'd9; rd_reg[1] = 5'd9;
        eval("pre_rst");
        check("pre_rst.busy", 64'(rd_busy_b[1]), 64'd1);
        #2 rst_n = 1'b0;
        model_reset();
        eval("async_rst");
        check("async_rst.data", 64'(rd_data_b[0]), 64'd0);
        check("async_rst.cnt", 64'(cnt_b), 64'd0);
        we = 1'b1; wr_reg = 5'd12; wr_data = 32'hCAFE; iss = 1'b1; iss_reg = 5'd12;
        advance();
        idle();
        rst_n = 1'b1;
        rd_reg[0] = 5'd12; rd_reg[1] = 5'd9;
        eval("rst_discard");
        we = 1'b1; wr_reg = 5'd12; wr_data = 32'hBEEF;
        advance();
        idle();
        eval("first_write");
        check("first_write.x12", 64'(rd_data_n[0]), 64'hBEEF);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            we      = 1'($urandom_range(0, 1));
            wr_reg  = AW'($urandom_range(0, NR - 1));
            wr_data = $urandom;
            iss     = ($urandom_range(0, 2) == 0);
            iss_reg = ($urandom_range(0, 3) == 0) ? wr_reg : AW'($urandom_range(0, NR - 1));
            flush   = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NP; p++) begin
                rd_reg[p] = ($urandom_range(0, 3) == 0) ? wr_reg : AW'($urandom_range(0, NR - 1));
            end
            if ($urandom_range(0, 7) == 0) rd_reg[1] = rd_reg[0];
            eval($sformatf("rnd%0d", n));
            advance();
        end
        idle();
        eval("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, >=2.
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding in the same cycle, 0 = none.
REQ-005 SHALL define AW = $clog2(NREGS).
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port Read_reg  input  NRD x AW  read addresses.
REQ-009 SHALL have port Read_data  output  NRD x XLEN  read data, combinational.
REQ-010 SHALL have port Read_busy  output  NRD  pending-write flag per read port, combinational.
REQ-011 SHALL have port RegWrite  input  1  writeback enable.
REQ-012 SHALL have port Write_reg  input  AW  writeback address.
REQ-013 SHALL have port Write_data  input  XLEN  writeback data.
REQ-014 SHALL have port Issue  input  1  marks a destination as pending, e.g. a load issued to the LSU.
REQ-015 SHALL have port Issue_reg  input  AW  pending destination.
REQ-016 SHALL have port Flush  input  1  clears all pending marks.
REQ-017 SHALL have port Busy_cnt  output  AW+1  number of registers currently pending.

Function
REQ-018 SHALL capture Write_data into reg[Write_reg] on the rising edge of clk when RegWrite=1 and Write_reg!=0.
REQ-019 SHALL always read reg 0 as 0 and never mark it busy; writes and issues to reg 0 SHALL be ignored.
REQ-020 SHALL, for each port i, drive Read_data[i] = reg[Read_reg[i]] combinationally.
REQ-021 SHALL, when BYPASS=1, RegWrite=1, Write_reg=Read_reg[i] and Write_reg!=0, drive Read_data[i]=Write_data in the same cycle.
REQ-022 SHALL hold a busy bit per register: set on the edge when Issue=1 and Issue_reg!=0; cleared on the edge when RegWrite=1 and Write_reg matches.
REQ-023 SHALL, when Issue and RegWrite target the same register in the same cycle, leave that register busy (the new issue wins) and still perform the write.
REQ-024 SHALL, on Flush=1, clear every busy bit on that edge; a same-cycle Issue SHALL still set its bit (Issue wins over Flush); a same-cycle RegWrite SHALL still write data.
REQ-025 SHALL drive Read_busy[i] = busy[Read_reg[i]], masked to 0 when BYPASS=1 and a same-cycle RegWrite matches Read_reg[i].
REQ-026 SHALL keep Busy_cnt registered and equal to the popcount of the busy bits after every edge; range 0..NREGS-1.
REQ-027 SHALL treat an Issue to an already-busy register as a no-op for Busy_cnt; a RegWrite to a non-busy register SHALL leave Busy_cnt unchanged.
REQ-028 SHALL give all read ports independent and identical behaviour, including when several ports read the same address.

Reset
REQ-029 SHALL, while rst_n=0, clear all registers to 0, all busy bits to 0 and Busy_cnt to 0, asynchronously.
REQ-030 SHALL, during reset, output Read_data=0 and Read_busy=0 for every address, including when BYPASS=1 and RegWrite=1.
REQ-031 SHALL discard any in-flight Issue or RegWrite coinciding with reset assertion; the first write is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 SHALL import package rf_pkg, which holds the XLEN/NREGS defaults, the AW helper function and the popcount function.
REQ-033 SHALL put the busy bits and Busy_cnt in one sub-module, rf_scoreboard; the data array, read muxes and bypass stay in reg_file_sb.

Verification
REQ-034 SHALL cover: reset, then write x5=0xDEADBEEF, read it on both ports next cycle -> 0xDEADBEEF on both, Read_busy=0.
REQ-035 SHALL cover: write x0=0x12345678, read x0 -> 0; Issue x0 -> Busy_cnt stays 0.
REQ-036 SHALL cover: BYPASS=1, write x7=0xA5A5A5A5 while reading x7 in the same cycle -> Read_data=0xA5A5A5A5 that cycle; BYPASS=0 -> old value 0.
REQ-037 SHALL cover: Issue x3, x4 -> Busy_cnt=2; RegWrite x3 together with Issue x3 -> x3 still busy, Busy_cnt=2; Flush -> Busy_cnt=0.
REQ-038 SHALL cover: mid-operation with x9 busy and holding 0x55, assert rst_n=0 between edges -> Read_data=0, Read_busy=0, Busy_cnt=0 immediately.
